// File: rtl/seg_capture_pkg.sv
// Shared definitions for seg_capture: active-low glyph table (hex2led encoding),
// SEG bus bit positions and the capture FSM state type.
package seg_capture_pkg;

  // SEG bus layout is {G,F,E,D,C,B,A,DP}
  localparam int SEG_DP = 0;
  localparam int SEG_A  = 1;
  localparam int SEG_G  = 7;

  // Index i holds the {G..A} active-low glyph for hex value i
  localparam logic [15:0][6:0] GLYPHS = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} state_e;

endpackage

// File: rtl/seg_capture_seg2hex.sv
// Combinational inverse of hex2led: maps a 7-bit active-low glyph back to its
// hex value, flagging patterns that are not one of the 16 glyphs.
module seg2hex
  import seg_capture_pkg::*;
(
  input  logic [6:0] glyph_i,
  output logic [3:0] hex_o,
  output logic       bad_o
);

  always_comb begin
    // NOTE: every output gets a default before the search so no latch is inferred.
    hex_o = 4'h0;
    bad_o = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (glyph_i == GLYPHS[i]) begin
        hex_o = 4'(i);
        bad_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_capture.sv
// Multiplexed 7-segment bus monitor: rebuilds per-digit hex/DP values and publishes
// a frame once all digits are seen. Optional STALE timeout: SEG_CAPTURE_TIMEOUT_EN.
module seg_capture
  import seg_capture_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SETTLE_CYC  = 4
`ifdef SEG_CAPTURE_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1048576
`endif
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [NUM_DIGITS-1:0]   AN,
  input  logic [7:0]              SEG,
  output logic [4*NUM_DIGITS-1:0] DIGITS,
  output logic [NUM_DIGITS-1:0]   DP,
  output logic                    VALID,
  output logic                    ERR,
  output logic                    STALE
);

  localparam logic [7:0] SETTLE_MAX = 8'(SETTLE_CYC);

  state_e                  state_q, state_d;
  logic [NUM_DIGITS-1:0]   an_q, pat_an_q, pat_an_d;
  logic [7:0]              seg_q, pat_seg_q, pat_seg_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d, shadow_dp_q, shadow_dp_d, dp_q, dp_d;
  logic [4*NUM_DIGITS-1:0] shadow_hex_q, shadow_hex_d, digits_q, digits_d;
  logic                    valid_q, valid_d, err_q, err_d;

  logic [3:0] cap_hex;
  logic       cap_bad, capture;
  logic       an_one_hot, an_illegal, pat_changed;

  assign an_one_hot  = ($countones(~an_q) == 1);
  assign an_illegal  = ($countones(~an_q) > 1);
  assign pat_changed = ({an_q, seg_q} != {pat_an_q, pat_seg_q});

  // The settled pattern, not the live bus, is what gets decoded on capture
  seg2hex u_seg2hex (
    .glyph_i (pat_seg_q[SEG_G:SEG_A]),
    .hex_o   (cap_hex),
    .bad_o   (cap_bad)
  );

  always_comb begin
    state_d   = state_q;
    pat_an_d  = pat_an_q;
    pat_seg_d = pat_seg_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    capture   = 1'b0;
    if (an_illegal) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (an_one_hot) begin
            pat_an_d  = an_q;
            pat_seg_d = seg_q;
            cnt_d     = 8'd1;
            state_d   = SETTLE;
          end
        end
        SETTLE: begin
          if (pat_changed) begin
            if (an_one_hot) begin
              pat_an_d  = an_q;
              pat_seg_d = seg_q;
              cnt_d     = 8'd1;
            end else begin
              state_d = IDLE;
            end
          end else if (cnt_q >= SETTLE_MAX) begin
            state_d = CAPTURE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        CAPTURE: begin
          capture = 1'b1;
          err_d   = err_q | cap_bad;
          state_d = HOLD;
        end
        HOLD: begin
          if (an_q != pat_an_q) begin
            if (an_one_hot) begin
              pat_an_d  = an_q;
              pat_seg_d = seg_q;
              cnt_d     = 8'd1;
              state_d   = SETTLE;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    shadow_hex_d = shadow_hex_q;
    shadow_dp_d  = shadow_dp_q;
    seen_d       = seen_q;
    digits_d     = digits_q;
    dp_d         = dp_q;
    valid_d      = 1'b0;
    // Publish the pre-capture shadow; a same-cycle capture starts the next frame
    if (&seen_q) begin
      digits_d = shadow_hex_q;
      dp_d     = shadow_dp_q;
      valid_d  = 1'b1;
      seen_d   = '0;
    end
    if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (!pat_an_q[i]) begin
          shadow_hex_d[4*i +: 4] = cap_hex;
          shadow_dp_d[i]         = ~pat_seg_q[SEG_DP];
        end
      end
      seen_d = seen_d | ~pat_an_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: the shadow store is a few flops and a mid-frame reset must discard it, so it is reset too.
      state_q      <= IDLE;
      an_q         <= '1;
      seg_q        <= '1;
      pat_an_q     <= '1;
      pat_seg_q    <= '1;
      cnt_q        <= '0;
      seen_q       <= '0;
      shadow_hex_q <= '0;
      shadow_dp_q  <= '0;
      digits_q     <= '0;
      dp_q         <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q      <= state_d;
      an_q         <= AN;
      seg_q        <= SEG;
      pat_an_q     <= pat_an_d;
      pat_seg_q    <= pat_seg_d;
      cnt_q        <= cnt_d;
      seen_q       <= seen_d;
      shadow_hex_q <= shadow_hex_d;
      shadow_dp_q  <= shadow_dp_d;
      digits_q     <= digits_d;
      dp_q         <= dp_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign DIGITS = digits_q;
  assign DP     = dp_q;
  assign VALID  = valid_q;
  assign ERR    = err_q;

`ifdef SEG_CAPTURE_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_MAX = 32'(TIMEOUT_CYC);

  logic [31:0] idle_cnt_q, idle_cnt_d;

  // Cleared together with the VALID pulse so STALE drops on the VALID cycle
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (valid_d) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != TIMEOUT_MAX) begin
      idle_cnt_d = idle_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign STALE = (idle_cnt_q == TIMEOUT_MAX);
`else
  assign STALE = 1'b0;
`endif

endmodule

// File: tb/tb_seg_capture.sv
// Self-checking bench for seg_capture: directed scans push expected frames into a
// queue; a monitor pops and compares on every VALID pulse.
module tb_seg_capture;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [3:0]  AN;
  logic [7:0]  SEG;
  logic [15:0] DIGITS;
  logic [3:0]  DP;
  logic        VALID, ERR, STALE;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp;
  } frame_t;

  frame_t exp_q[$];
  frame_t exp_f;
  int     n_checks = 0;
  int     n_fail   = 0;
  int     n_valid  = 0;
  logic   prev_valid = 1'b0;

  seg_capture dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .AN      (AN),
    .SEG     (SEG),
    .DIGITS  (DIGITS),
    .DP      (DP),
    .VALID   (VALID),
    .ERR     (ERR),
    .STALE   (STALE)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every VALID must match the oldest outstanding expected frame
  always @(negedge CLK) begin
    if (RESET_N === 1'b1 && VALID === 1'b1) begin
      n_valid++;
      check("valid_one_cycle", 32'(prev_valid), 32'd0);
      check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_f = exp_q.pop_front();
        check("frame_digits", 32'(DIGITS), 32'(exp_f.digits));
        check("frame_dp", 32'(DP), 32'(exp_f.dp));
      end
    end
    prev_valid = VALID;
  end

  task automatic dwell(input logic [3:0] an, input logic [7:0] seg, input int n);
    AN  = an;
    SEG = seg;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic digit(input int i, input logic [7:0] seg);
    logic [3:0] an;
    an = 4'b0001 << i;
    dwell(~an, seg, 16);
  endtask

  task automatic expect_frame(input logic [15:0] d, input logic [3:0] p);
    exp_q.push_back(frame_t'{digits: d, dp: p});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_digits"}, 32'(DIGITS), 32'd0);
    check({tag, "_dp"},     32'(DP),     32'd0);
    check({tag, "_valid"},  32'(VALID),  32'd0);
    check({tag, "_err"},    32'(ERR),    32'd0);
    check({tag, "_stale"},  32'(STALE),  32'd0);
  endtask

  initial begin
    RESET_N = 1'b0;
    AN      = 4'hF;
    SEG     = 8'hFF;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RESET_N = 1'b1;
    dwell(4'hF, 8'hFF, 2);

    // Clean scan: 0, 1, 8, 8.
    expect_frame(16'h8810, 4'b1000);
    digit(0, 8'h81); digit(1, 8'hF3); digit(2, 8'h01); digit(3, 8'h00);
    dwell(4'hF, 8'hFF, 4);
    check("clean_drained", 32'(exp_q.size()), 32'd0);
    check("clean_valids", 32'(n_valid), 32'd1);
    check("clean_err", 32'(ERR), 32'd0);

    // Ghosting: 'A' for 2 cycles then '5' on digit 0; only '5' may be captured
    expect_frame(16'hF325, 4'b1010);
    dwell(4'b1110, 8'h11, 2);
    dwell(4'b1110, 8'h25, 10);
    digit(1, 8'h48); digit(2, 8'h61); digit(3, 8'h1C);
    dwell(4'hF, 8'hFF, 4);
    check("ghost_drained", 32'(exp_q.size()), 32'd0);
    check("ghost_valids", 32'(n_valid), 32'd2);
    check("ghost_err", 32'(ERR), 32'd0);

    // Recapture: digit 0 seen as '1' then '9' before completion; latest wins
    expect_frame(16'h4329, 4'b0000);
    digit(0, 8'hF3); digit(1, 8'h49); digit(0, 8'h21); digit(2, 8'h61); digit(3, 8'h33);
    dwell(4'hF, 8'hFF, 4);
    check("recap_drained", 32'(exp_q.size()), 32'd0);
    check("recap_valids", 32'(n_valid), 32'd3);

    // Illegal anode after digits 2,3: capturing it would complete the frame early
    expect_frame(16'hDCBE, 4'b0000);
    digit(2, 8'h8D); digit(3, 8'h43);
    dwell(4'b1100, 8'h21, 10);
    check("illegal_err", 32'(ERR), 32'd1);
    check("illegal_no_valid", 32'(n_valid), 32'd3);
    check("illegal_digits_hold", 32'(DIGITS), 32'h4329);
    digit(0, 8'h0D); digit(1, 8'h07);
    dwell(4'hF, 8'hFF, 4);
    check("illegal_drained", 32'(exp_q.size()), 32'd0);
    check("illegal_valids", 32'(n_valid), 32'd4);
    check("illegal_err_sticky", 32'(ERR), 32'd1);

    // Reset after two captured digits; the partial frame must be forgotten
    digit(0, 8'hF3); digit(1, 8'h49);
    AN  = 4'b1011;
    SEG = 8'h61;
    repeat (3) @(posedge CLK);
    #1;
    RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_outputs("midreset");
    AN  = 4'hF;
    SEG = 8'hFF;
    RESET_N = 1'b1;
    dwell(4'hF, 8'hFF, 2);
    expect_frame(16'h6543, 4'b0001);
    digit(2, 8'h25); digit(3, 8'h05);
    check("midreset_no_early_valid", 32'(n_valid), 32'd4);
    digit(0, 8'h60); digit(1, 8'h33);
    dwell(4'hF, 8'hFF, 4);
    check("midreset_drained", 32'(exp_q.size()), 32'd0);
    check("midreset_valids", 32'(n_valid), 32'd5);
    check("midreset_err", 32'(ERR), 32'd0);

    // Bad glyph on digit 2: stored as 0, frame still published, ERR set
    expect_frame(16'h00A7, 4'b1000);
    digit(0, 8'hF1); digit(1, 8'h11); digit(2, 8'hFF); digit(3, 8'h80);
    dwell(4'hF, 8'hFF, 4);
    check("bad_drained", 32'(exp_q.size()), 32'd0);
    check("bad_valids", 32'(n_valid), 32'd6);
    check("bad_err", 32'(ERR), 32'd1);
    check("bad_nibble", 32'(DIGITS[11:8]), 32'd0);
    check("stale_off", 32'(STALE), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
